// File: rtl/branch_ctrl.sv
// Branch resolution controller: captures a decoded branch, evaluates it with an
// external comparator, and offers the taken target to fetch followed by a flush.
module branch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_funct3,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      br_imm,
  input  logic [31:0]      br_rs1,
  input  logic [31:0]      br_rs2,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  output logic             cmp_un,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             done,
  output logic             illegal_br,
  output logic             misalign,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [1:0]       fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // the offering side holds valid and its payload stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, REDIRECT = 2'd2, FLUSH = 2'd3} state_t;

  state_t      state, state_next;
  logic [2:0]  funct3_q;
  logic [31:0] pc_q, imm_q, rs1_q, rs2_q;
  logic [3:0]  flush_cnt;
  logic [31:0] target;
  logic        legal, taken;
  logic        accept, ev_illegal, ev_not_taken, ev_misalign, ev_go, handshake;

  assign br_ready  = (state == IDLE);
  assign accept    = br_valid & br_ready;
  assign cmp_a     = rs1_q;
  assign cmp_b     = rs2_q;
  assign cmp_un    = funct3_q[1];
  assign fsm_state = state;

  always_comb begin
    state_next   = state;
    legal        = funct3_q[2] | ~funct3_q[1];
    target       = pc_q + imm_q;
    taken        = 1'b0;
    ev_illegal   = 1'b0;
    ev_not_taken = 1'b0;
    ev_misalign  = 1'b0;
    ev_go        = 1'b0;
    handshake    = 1'b0;
    case (funct3_q)
      3'b000:         taken = cmp_eq;
      3'b001:         taken = ~cmp_eq;
      3'b100, 3'b110: taken = cmp_lt;
      3'b101, 3'b111: taken = ~cmp_lt;
      default:        taken = 1'b0;
    endcase
    case (state)
      IDLE: if (br_valid) state_next = EVAL;
      EVAL: begin
        state_next = IDLE;
        if (!legal)                  ev_illegal   = 1'b1;
        else if (!taken)             ev_not_taken = 1'b1;
        else if (target[1:0] != 2'b00) ev_misalign = 1'b1;
        else begin
          ev_go      = 1'b1;
          state_next = REDIRECT;
        end
      end
      REDIRECT: if (redirect_ready) begin
        handshake  = 1'b1;
        state_next = FLUSH;
      end
      FLUSH: if (flush_cnt == 4'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      funct3_q       <= 3'b000;
      pc_q           <= 32'h0;
      imm_q          <= 32'h0;
      rs1_q          <= 32'h0;
      rs2_q          <= 32'h0;
      redirect_pc    <= 32'h0;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      flush_cnt      <= 4'd0;
      done           <= 1'b0;
      illegal_br     <= 1'b0;
      misalign       <= 1'b0;
      br_count       <= '0;
      taken_count    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        funct3_q <= br_funct3;
        pc_q     <= br_pc;
        imm_q    <= br_imm;
        rs1_q    <= br_rs1;
        rs2_q    <= br_rs2;
      end
      if (ev_go) redirect_pc <= target;
      redirect_valid <= (state_next == REDIRECT);
      flush          <= (state_next == FLUSH);
      // Loaded with N-1 so the FLUSH state lasts exactly FLUSH_CYCLES cycles.
      if (handshake) flush_cnt <= 4'(FLUSH_CYCLES - 1);
      else if (state == FLUSH && flush_cnt != 4'd0) flush_cnt <= flush_cnt - 4'd1;
      done       <= ev_illegal | ev_not_taken | ev_misalign | handshake;
      illegal_br <= ev_illegal;
      misalign   <= ev_misalign;
      if ((ev_not_taken | ev_misalign | handshake) && !(&br_count))
        br_count <= br_count + CNT_W'(1);
      if (handshake && !(&taken_count))
        taken_count <= taken_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: table of branch vectors plus reset and
// saturation sequences; a narrow-counter instance covers saturation quickly.
module tb_branch_ctrl;

  localparam int K_NT = 0, K_TAKEN = 1, K_MIS = 2, K_ILL = 3;
  localparam int FC = 2;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] pc, imm, rs1, rs2;
    int          delay;
    int          kind;
    logic [31:0] exp_pc;
    logic        exp_un;
  } vec_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        br_valid = 1'b0, redirect_ready = 1'b0;
  logic [2:0]  br_funct3 = 3'b000;
  logic [31:0] br_pc = 32'h0, br_imm = 32'h0, br_rs1 = 32'h0, br_rs2 = 32'h0;

  logic        br_ready, cmp_un, cmp_lt, cmp_eq, redirect_valid, flush, done, illegal_br, misalign;
  logic [31:0] cmp_a, cmp_b, redirect_pc;
  logic [15:0] br_count, taken_count;
  logic [1:0]  fsm_state;

  logic        br_ready_s, cmp_un_s, cmp_lt_s, cmp_eq_s, redirect_valid_s, flush_s, done_s;
  logic        illegal_br_s, misalign_s;
  logic [31:0] cmp_a_s, cmp_b_s, redirect_pc_s;
  logic [2:0]  br_count_s, taken_count_s;
  logic [1:0]  fsm_state_s;

  int          n_cmp = 0, n_fail = 0;
  logic [15:0] exp_br = 16'h0, exp_tk = 16'h0;
  logic [2:0]  exp_br_s = 3'h0, exp_tk_s = 3'h0;
  vec_t        vecs[11];

  always #5 clk = ~clk;

  // External comparator for each instance.
  always_comb begin
    cmp_eq   = (cmp_a == cmp_b);
    cmp_lt   = cmp_un ? (cmp_a < cmp_b) : ($signed(cmp_a) < $signed(cmp_b));
    cmp_eq_s = (cmp_a_s == cmp_b_s);
    cmp_lt_s = cmp_un_s ? (cmp_a_s < cmp_b_s) : ($signed(cmp_a_s) < $signed(cmp_b_s));
  end

  branch_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_funct3(br_funct3), .br_pc(br_pc), .br_imm(br_imm), .br_rs1(br_rs1), .br_rs2(br_rs2),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_un(cmp_un), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .flush(flush), .done(done), .illegal_br(illegal_br), .misalign(misalign),
    .br_count(br_count), .taken_count(taken_count), .fsm_state(fsm_state)
  );

  branch_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready_s),
    .br_funct3(br_funct3), .br_pc(br_pc), .br_imm(br_imm), .br_rs1(br_rs1), .br_rs2(br_rs2),
    .cmp_a(cmp_a_s), .cmp_b(cmp_b_s), .cmp_un(cmp_un_s), .cmp_lt(cmp_lt_s), .cmp_eq(cmp_eq_s),
    .redirect_valid(redirect_valid_s), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc_s),
    .flush(flush_s), .done(done_s), .illegal_br(illegal_br_s), .misalign(misalign_s),
    .br_count(br_count_s), .taken_count(taken_count_s), .fsm_state(fsm_state_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_counters();
    check("br_count", 32'(br_count), 32'(exp_br));
    check("taken_count", 32'(taken_count), 32'(exp_tk));
    check("br_count_sat", 32'(br_count_s), 32'(exp_br_s));
    check("taken_count_sat", 32'(taken_count_s), 32'(exp_tk_s));
  endtask

  task automatic model_update(input int kind);
    if (kind != K_ILL) begin
      if (exp_br != 16'hFFFF) exp_br = exp_br + 16'd1;
      if (exp_br_s != 3'h7) exp_br_s = exp_br_s + 3'd1;
    end
    if (kind == K_TAKEN) begin
      if (exp_tk != 16'hFFFF) exp_tk = exp_tk + 16'd1;
      if (exp_tk_s != 3'h7) exp_tk_s = exp_tk_s + 3'd1;
    end
  endtask

  // Called at a negedge; returns at a negedge with the DUT back in IDLE
  // (or just after reset release when reset_in_flush is set).
  task automatic run_branch(input vec_t v, input bit reset_in_flush);
    int w, n;
    w = 0;
    while (!br_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("ready_timeout", 32'(br_ready), 32'd1);
    br_valid = 1'b1; br_funct3 = v.f3; br_pc = v.pc; br_imm = v.imm;
    br_rs1 = v.rs1; br_rs2 = v.rs2;
    @(posedge clk); #1;
    br_valid = 1'b0;
    @(negedge clk);
    check("eval_ready", 32'(br_ready), 32'd0);
    check("cmp_un", 32'(cmp_un), 32'(v.exp_un));
    check("cmp_a", cmp_a, v.rs1);
    check("cmp_b", cmp_b, v.rs2);
    @(negedge clk);
    model_update(v.kind);
    if (v.kind != K_TAKEN) begin
      check("out_done", 32'(done), 32'd1);
      check("out_illegal", 32'(illegal_br), 32'(v.kind == K_ILL));
      check("out_misalign", 32'(misalign), 32'(v.kind == K_MIS));
      check("out_redirect_valid", 32'(redirect_valid), 32'd0);
      check("out_ready", 32'(br_ready), 32'd1);
      @(negedge clk);
      check("done_pulse_end", 32'(done), 32'd0);
      check("no_flush", 32'(flush), 32'd0);
    end else begin
      check("out_redirect_valid", 32'(redirect_valid), 32'd1);
      check("out_redirect_pc", redirect_pc, v.exp_pc);
      check("out_done_early", 32'(done), 32'd0);
      for (int d = 0; d < v.delay; d++) begin
        br_valid = 1'b1; br_funct3 = 3'b001; br_rs1 = 32'hDEAD0000 + 32'(d);
        @(negedge clk);
        check("hold_valid", 32'(redirect_valid), 32'd1);
        check("hold_pc", redirect_pc, v.exp_pc);
        check("hold_ready", 32'(br_ready), 32'd0);
        check("hold_flush", 32'(flush), 32'd0);
      end
      br_valid = 1'b0;
      redirect_ready = 1'b1;
      @(posedge clk); #1;
      redirect_ready = 1'b0;
      @(negedge clk);
      check("hs_done", 32'(done), 32'd1);
      check("hs_flush", 32'(flush), 32'd1);
      check("hs_valid_drop", 32'(redirect_valid), 32'd0);
      check("hs_operands_kept", cmp_a, v.rs1);
      if (reset_in_flush) begin
        rst_n = 1'b0;
        #1;
        exp_br = 16'h0; exp_tk = 16'h0; exp_br_s = 3'h0; exp_tk_s = 3'h0;
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(br_ready), 32'd1);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check_counters();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_flush", 32'(flush), 32'd0);
        check("post_rst_ready", 32'(br_ready), 32'd1);
        check("post_rst_valid", 32'(redirect_valid), 32'd0);
        return;
      end
      n = 0;
      for (int i = 0; i < 20; i++) begin
        if (!flush) break;
        n++;
        @(negedge clk);
      end
      check("flush_cycles", 32'(n), 32'(FC));
      check("flush_end_ready", 32'(br_ready), 32'd1);
    end
    check_counters();
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 0, K_TAKEN, 32'h120, 1'b0};
    vecs[1]  = '{3'b100, 32'h200, 32'h40, 32'hFFFFFFFF, 32'd1, 0, K_TAKEN, 32'h240, 1'b0};
    vecs[2]  = '{3'b110, 32'h200, 32'h40, 32'hFFFFFFFF, 32'd1, 0, K_NT, 32'h0, 1'b1};
    vecs[3]  = '{3'b001, 32'h1000, 32'hFFFFFFFC, 32'd3, 32'd4, 3, K_TAKEN, 32'h00000FFC, 1'b0};
    vecs[4]  = '{3'b010, 32'h300, 32'h8, 32'd9, 32'd9, 0, K_ILL, 32'h0, 1'b1};
    vecs[5]  = '{3'b000, 32'h100, 32'h2, 32'd7, 32'd7, 0, K_MIS, 32'h0, 1'b0};
    vecs[6]  = '{3'b101, 32'hFFFFFFF0, 32'h20, 32'd1, 32'd1, 1, K_TAKEN, 32'h00000010, 1'b0};
    vecs[7]  = '{3'b111, 32'h400, 32'h4, 32'd0, 32'hFFFFFFFF, 0, K_NT, 32'h0, 1'b1};
    vecs[8]  = '{3'b000, 32'h500, 32'h4, 32'd1, 32'd2, 0, K_NT, 32'h0, 1'b0};
    vecs[9]  = '{3'b011, 32'h600, 32'h4, 32'd1, 32'd1, 0, K_ILL, 32'h0, 1'b1};
    vecs[10] = '{3'b001, 32'h700, 32'h4, 32'd6, 32'd6, 0, K_NT, 32'h0, 1'b0};

    repeat (2) @(negedge clk);
    check("reset_ready", 32'(br_ready), 32'd1);
    check("reset_valid", 32'(redirect_valid), 32'd0);
    check("reset_flush", 32'(flush), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'h0);
    check("reset_cmp_a", cmp_a, 32'h0);
    check_counters();
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_branch(vecs[i], 1'b0);

    // Extra legal branches push the narrow counters past saturation.
    for (int i = 0; i < 4; i++) run_branch(vecs[8], 1'b0);
    for (int i = 0; i < 5; i++) run_branch(vecs[0], 1'b0);

    run_branch(vecs[0], 1'b1);
    run_branch(vecs[1], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, number of cycles flush is held after an accepted redirect (legal range 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 br_valid  input  1  decode presents a branch operation.
REQ-005 br_ready  output  1  block accepts a branch this cycle.
REQ-006 br_funct3  input  3  RISC-V branch funct3.
REQ-007 br_pc, br_imm, br_rs1, br_rs2  input  32 each  branch PC, sign-extended offset, operands.
REQ-008 cmp_a, cmp_b  output  32 each  operands driven to the external comparator.
REQ-009 cmp_un  output  1  unsigned-compare select to the comparator.
REQ-010 cmp_lt, cmp_eq  input  1 each  comparator results (combinational from cmp_a/cmp_b/cmp_un).
REQ-011 redirect_valid  output  1  taken-branch target offered to fetch.
REQ-012 redirect_ready  input  1  fetch accepts the target.
REQ-013 redirect_pc  output  32  branch target.
REQ-014 flush  output  1  squash younger pipeline stages.
REQ-015 done  output  1  one-cycle pulse: branch resolved (any outcome).
REQ-016 illegal_br, misalign  output  1 each  one-cycle error pulses.
REQ-017 br_count, taken_count  output  16 each  saturating statistics counters.

Function
REQ-018 FSM states: IDLE, EVAL, REDIRECT, FLUSH; br_ready SHALL be 1 only in IDLE.
REQ-019 Accept = br_valid & br_ready; on accept, funct3/pc/imm/rs1/rs2 SHALL be registered and state SHALL go IDLE->EVAL.
REQ-020 cmp_a/cmp_b SHALL be the registered rs1/rs2; cmp_un SHALL equal registered funct3[1].
REQ-021 In EVAL (exactly one cycle) cmp_lt/cmp_eq SHALL be sampled; taken = BEQ(000):eq, BNE(001):!eq, BLT(100)/BLTU(110):lt, BGE(101)/BGEU(111):!lt.
REQ-022 funct3 010/011: illegal_br pulse, not taken, done pulse, state->IDLE.
REQ-023 Target = pc + imm modulo 2^32 (wrap-around, no carry out).
REQ-024 Not taken: done pulse in the EVAL-exit cycle, state->IDLE; no redirect, no flush.
REQ-025 Taken with target[1:0] != 0: misalign pulse, done pulse, state->IDLE, no redirect.
REQ-026 Taken aligned: state->REDIRECT; redirect_valid=1 and redirect_pc stable until redirect_valid & redirect_ready.
REQ-027 On redirect handshake: done pulse, state->FLUSH; flush=1 for exactly FLUSH_CYCLES cycles starting the next cycle, then state->IDLE.
REQ-028 Minimum latency accept->done: 1 cycle (not taken); taken: redirect_valid asserted first cycle after EVAL.
REQ-029 br_count SHALL increment on every done with a legal funct3; taken_count on every taken, aligned redirect handshake; both saturate at 16'hFFFF.
REQ-030 br_valid is ignored outside IDLE; no input is buffered.
REQ-031 Accept is possible in the cycle after the last flush cycle, or the cycle after a not-taken/error done.

Reset
REQ-032 rst_n low SHALL asynchronously force state=IDLE, all registered operands, redirect_pc, counters to 0, redirect_valid/flush/done/illegal_br/misalign to 0; br_ready SHALL be 1 from reset.
REQ-033 Reset asserted mid-REDIRECT or mid-FLUSH SHALL abort immediately with no further redirect or flush cycles.

Verification
REQ-034 BEQ rs1=rs2=5, pc=0x100, imm=0x20, redirect_ready=1 -> redirect_pc=0x120, done, flush high 2 cycles, taken_count=1.
REQ-035 BLT rs1=0xFFFFFFFF, rs2=1 -> cmp_un=0, taken; BLTU same operands -> cmp_un=1, not taken, done 1 cycle after EVAL entry, no flush.
REQ-036 BNE taken, redirect_ready low 3 cycles -> redirect_valid/redirect_pc 0x...held 3 cycles, br_valid pulses ignored, flush starts after handshake.
REQ-037 funct3=010 -> illegal_br pulse, br_count unchanged; BEQ taken with pc=0x100, imm=0x2 -> misalign pulse, no redirect_valid.
REQ-038 pc=0xFFFFFFF0, imm=0x20, taken -> redirect_pc=0x00000010; preload 0xFFFF legal branches -> br_count stays 0xFFFF.
REQ-039 rst_n low during FLUSH cycle 1 -> flush=0 immediately, counters 0, br_ready=1 after release.
